stack_unit: RTL and testbench

STACK_UNIT -- requirements
Module: stack_unit

---
 rtl/stack_pkg.sv | 29 ++
 rtl/stack_sp_calc.sv | 28 ++
 rtl/stack_unit.sv | 113 +++++++++++
 tb/tb_stack_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared types and defaults for the hardware call/data stack.
// Op encoding matches the req_op port.
package stack_pkg;

  typedef enum logic [1:0] {
    OP_PUSH = 2'd0,
    OP_POP  = 2'd1,
    OP_CALL = 2'd2,
    OP_RET  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADJ  = 2'd1,
    S_MEM  = 2'd2,
    S_RESP = 2'd3
  } state_e;

  localparam int          DEF_DATA_W      = 32;
  localparam int          DEF_ADDR_W      = 32;
  localparam int          DEF_WORD_BYTES  = 4;
  localparam logic [31:0] DEF_STACK_BASE  = 32'h0000_0400;
  localparam logic [31:0] DEF_STACK_LIMIT = 32'h0000_0300;

  function automatic logic is_grow(op_e op);
    return (op == OP_PUSH) || (op == OP_CALL);
  endfunction

endpackage

// File: rtl/stack_sp_calc.sv
// Next-SP and overflow/underflow computation for a
// full-descending stack. Purely combinational.
module stack_sp_calc
  import stack_pkg::*;
#(
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter int                WORD_BYTES  = DEF_WORD_BYTES,
  parameter logic [ADDR_W-1:0] STACK_BASE  = ADDR_W'(DEF_STACK_BASE),
  parameter logic [ADDR_W-1:0] STACK_LIMIT = ADDR_W'(DEF_STACK_LIMIT)
) (
  input  logic [ADDR_W-1:0] sp,
  input  op_e               op,
  output logic [ADDR_W-1:0] nsp,
  output logic              err
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORD_BYTES);

  logic grow;

  always_comb begin
    grow = is_grow(op);
    nsp  = grow ? sp - STEP : sp + STEP;
    err  = grow ? (sp == STACK_LIMIT)
                : (sp == STACK_BASE);
  end

endmodule

// File: rtl/stack_unit.sv
// Push/pop/call/ret stack engine: IDLE -> ADJ -> MEM -> RESP,
// with errors skipping MEM and leaving SP untouched.
module stack_unit
  import stack_pkg::*;
#(
  parameter int                DATA_W      = DEF_DATA_W,
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter int                WORD_BYTES  = DEF_WORD_BYTES,
  parameter logic [ADDR_W-1:0] STACK_BASE  = ADDR_W'(DEF_STACK_BASE),
  parameter logic [ADDR_W-1:0] STACK_LIMIT = ADDR_W'(DEF_STACK_LIMIT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_data,
  input  logic [DATA_W-1:0] req_pc,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] sp
);

  localparam logic [ADDR_W-1:0] STEP_A = ADDR_W'(WORD_BYTES);
  localparam logic [DATA_W-1:0] STEP_D = DATA_W'(WORD_BYTES);

  if (!(STACK_BASE > STACK_LIMIT) ||
      (((STACK_BASE - STACK_LIMIT) % STEP_A) != '0)) begin : g_bad_cfg
    $error("stack_unit: bad STACK_BASE/STACK_LIMIT/WORD_BYTES");
  end

  state_e            state, state_n;
  op_e               op_q;
  logic [DATA_W-1:0] data_q, pc_q, rsp_q;
  logic [ADDR_W-1:0] sp_q, nsp_q, calc_nsp;
  logic              err_q, calc_err, grow_q, in_mem;

  stack_sp_calc #(
    .ADDR_W      (ADDR_W),
    .WORD_BYTES  (WORD_BYTES),
    .STACK_BASE  (STACK_BASE),
    .STACK_LIMIT (STACK_LIMIT)
  ) u_calc (
    .sp  (sp_q),
    .op  (op_q),
    .nsp (calc_nsp),
    .err (calc_err)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (req_valid) state_n = S_ADJ;
      S_ADJ:  state_n = calc_err ? S_RESP : S_MEM;
      S_MEM:  state_n = S_RESP;
      S_RESP: if (rsp_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    grow_q    = is_grow(op_q);
    in_mem    = (state == S_MEM);
    req_ready = (state == S_IDLE) && !rst;
    rsp_valid = (state == S_RESP);
    rsp_data  = rsp_q;
    rsp_err   = err_q;
    sp        = sp_q;
    // a reset arriving mid-write must not reach memory
    mem_we    = in_mem && grow_q && !rst;
    mem_addr  = (in_mem && grow_q) ? nsp_q : sp_q;
    unique case (1'b1)
      (op_q == OP_CALL): mem_wdata = pc_q + STEP_D;
      default:           mem_wdata = data_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      op_q   <= OP_PUSH;
      data_q <= '0;
      pc_q   <= '0;
      sp_q   <= STACK_BASE;
      nsp_q  <= STACK_BASE;
      rsp_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_n;
      if (req_valid && req_ready) begin
        op_q   <= op_e'(req_op);
        data_q <= req_data;
        pc_q   <= req_pc;
      end
      if (state == S_ADJ) begin
        nsp_q <= calc_nsp;
        err_q <= calc_err;
        if (calc_err) rsp_q <= '0;
      end
      if (in_mem) begin
        sp_q  <= nsp_q;
        rsp_q <= grow_q ? data_q : mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_stack_unit.sv
// Table-driven bench for stack_unit with a response scoreboard
// and a behavioural data memory.
module tb_stack_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_data, req_pc;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, sp;
  logic        mem_we;

  stack_unit #(
    .DATA_W      (32),
    .ADDR_W      (32),
    .WORD_BYTES  (4),
    .STACK_BASE  (32'h0000_0400),
    .STACK_LIMIT (32'h0000_03F0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_data  (req_data),
    .req_pc    (req_pc),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .sp        (sp)
  );

  always #5 clk = ~clk;

  logic [31:0] tmem [0:255];
  int          n_wr = 0;
  assign mem_rdata = tmem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_we) begin
      tmem[mem_addr[9:2]] <= mem_wdata;
      n_wr <= n_wr + 1;
    end
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    logic [31:0] pc;
    logic [31:0] exp_data;
    logic [31:0] exp_wdata;
    logic [31:0] exp_sp;
    logic        exp_err;
    logic        chk_data;
  } vec_t;

  vec_t tbl [19];
  vec_t sb [$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] op,
                              input logic [31:0] d, pc, ed, ew, es,
                              input logic er);
    vec_t v;
    v.op = op; v.data = d; v.pc = pc; v.exp_data = ed;
    v.exp_wdata = ew; v.exp_sp = es; v.exp_err = er;
    v.chk_data = !er;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int stall);
    vec_t e;
    int   n, w0, wexp;
    sb.push_back(v);
    @(negedge clk);
    req_valid = 1'b1; req_op = v.op;
    req_data = v.data; req_pc = v.pc; rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk); n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0; void'(sb.pop_back()); return;
    end
    w0 = n_wr;
    @(negedge clk);
    req_valid = 1'b0; req_op = ~v.op;
    req_data = 32'hDEAD_BEEF; req_pc = 32'h0000_1234;
    n = 1;
    while (!rsp_valid && n < 10) begin
      if (mem_we) begin
        chk("wr_addr", mem_addr, v.exp_sp);
        chk("wr_data", mem_wdata, v.exp_wdata);
        chk("wr_cycle", n, 2);
      end else if (n != 2) begin
        chk("idle_addr_eq_sp", mem_addr, sp);
      end
      @(negedge clk); n++;
    end
    if (!rsp_valid) begin
      chk("rsp_timeout", 32'd0, 32'd1);
      void'(sb.pop_front()); return;
    end
    e = sb.pop_front();
    chk("latency", n, e.exp_err ? 2 : 3);
    chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.exp_err});
    if (e.chk_data) chk("rsp_data", rsp_data, e.exp_data);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall_ready", {31'd0, req_ready}, 32'd0);
      if (e.chk_data) chk("stall_data", rsp_data, e.exp_data);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    wexp = ((e.op == 2'd0 || e.op == 2'd2) && !e.exp_err) ? 1 : 0;
    chk("n_writes", n_wr - w0, wexp);
    chk("sp", sp, e.exp_sp);
    chk("ready_after", {31'd0, req_ready}, 32'd1);
    chk("valid_after", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int w0;
    for (int i = 0; i < 256; i++) tmem[i] = '0;
    rst = 1'b1; req_valid = 1'b0; req_op = 2'd0;
    req_data = '0; req_pc = '0; rsp_ready = 1'b0;

    tbl[0]  = mk(2'd0, 32'hAAAA_0001, 0, 32'hAAAA_0001, 32'hAAAA_0001, 32'h3FC, 0);
    tbl[1]  = mk(2'd1, 0, 0, 32'hAAAA_0001, 0, 32'h400, 0);
    tbl[2]  = mk(2'd0, 32'h11, 0, 32'h11, 32'h11, 32'h3FC, 0);
    tbl[3]  = mk(2'd0, 32'h22, 0, 32'h22, 32'h22, 32'h3F8, 0);
    tbl[4]  = mk(2'd1, 0, 0, 32'h22, 0, 32'h3FC, 0);
    tbl[5]  = mk(2'd1, 0, 0, 32'h11, 0, 32'h400, 0);
    tbl[6]  = mk(2'd2, 32'h80, 32'h40, 32'h80, 32'h44, 32'h3FC, 0);
    tbl[7]  = mk(2'd3, 0, 0, 32'h44, 0, 32'h400, 0);
    tbl[8]  = mk(2'd0, 32'h1, 0, 32'h1, 32'h1, 32'h3FC, 0);
    tbl[9]  = mk(2'd0, 32'h2, 0, 32'h2, 32'h2, 32'h3F8, 0);
    tbl[10] = mk(2'd0, 32'h3, 0, 32'h3, 32'h3, 32'h3F4, 0);
    tbl[11] = mk(2'd0, 32'h4, 0, 32'h4, 32'h4, 32'h3F0, 0);
    tbl[12] = mk(2'd0, 32'h5, 0, 0, 0, 32'h3F0, 1);
    tbl[13] = mk(2'd1, 0, 0, 32'h4, 0, 32'h3F4, 0);
    tbl[14] = mk(2'd1, 0, 0, 32'h3, 0, 32'h3F8, 0);
    tbl[15] = mk(2'd1, 0, 0, 32'h2, 0, 32'h3FC, 0);
    tbl[16] = mk(2'd1, 0, 0, 32'h1, 0, 32'h400, 0);
    tbl[17] = mk(2'd1, 0, 0, 0, 0, 32'h400, 1);
    tbl[18] = mk(2'd3, 0, 0, 0, 0, 32'h400, 1);

    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_sp", sp, 32'h400);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 19; i++) begin
      run_vec(tbl[i], 0);
      if (i == 6) chk("call_ret_slot", tmem[8'hFF], 32'h44);
    end

    // response held off by the consumer
    run_vec(mk(2'd0, 32'h77, 0, 32'h77, 32'h77, 32'h3FC, 0), 5);
    run_vec(mk(2'd1, 0, 0, 32'h77, 0, 32'h400, 0), 0);

    // reset landing in the MEM cycle of a push
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd0; req_data = 32'h55;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("mem_we_in_mem", {31'd0, mem_we}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mem_we_rst", {31'd0, mem_we}, 32'd0);
    w0 = n_wr;
    @(negedge clk);
    chk("rst_mem_nowrite", n_wr - w0, 0);
    chk("rst_mem_sp", sp, 32'h400);
    chk("rst_mem_ready", {31'd0, req_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_mem_ready_after", {31'd0, req_ready}, 32'd1);

    run_vec(mk(2'd0, 32'h99, 0, 32'h99, 32'h99, 32'h3FC, 0), 0);
    run_vec(mk(2'd1, 0, 0, 32'h99, 0, 32'h400, 0), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
